// File: rtl/pipeline_adder_ctrl.sv
// pipeline_adder_ctrl: valid/ready sequencer for a 4-stage stallable adder.
// Ports: in_* operand stream, out_* result stream, flush/drain control,
//        adder_* to/from the adder, op_count/stall_count saturating stats.
module pipeline_adder_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_cout,
    input  logic             flush,
    input  logic             drain,
    output logic             drain_done,
    output logic [31:0]      adder_a,
    output logic [31:0]      adder_b,
    output logic             adder_cin,
    output logic [3:0]       adder_stop,
    output logic [3:0]       adder_rst,
    input  logic [31:0]      adder_sum,
    input  logic             adder_cout,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t     state;
    logic [3:0] v;
    logic [3:0] v_nxt;
    logic [3:0] hold;
    logic       active;
    logic       accept;
    logic       handoff;
    logic       stalled;

    assign active = (state == S_RUN) || (state == S_DRAIN);

    // A stage stalls only if it holds data and everything below it is
    // stalled; bubbles keep moving so gaps collapse under back-pressure.
    assign hold[3] = active & v[3] & ~out_ready;
    assign hold[2] = v[2] & hold[3];
    assign hold[1] = v[1] & hold[2];
    assign hold[0] = v[0] & hold[1];

    // A flush request wins over both handshakes in its own cycle.
    assign in_ready  = (state == S_RUN) & ~hold[0] & ~flush & ~drain;
    assign out_valid = active & v[3] & ~flush;

    assign accept  = in_valid & in_ready;
    assign handoff = out_valid & out_ready;
    assign stalled = out_valid & ~out_ready;

    assign v_nxt[0] = hold[0] ? v[0] : accept;
    assign v_nxt[1] = hold[1] ? v[1] : v[0];
    assign v_nxt[2] = hold[2] ? v[2] : v[1];
    assign v_nxt[3] = hold[3] ? v[3] : v[2];

    assign drain_done = (state == S_DRAIN) && (v == 4'h0);

    assign adder_a    = in_a;
    assign adder_b    = in_b;
    assign adder_cin  = in_cin;
    assign adder_stop = hold;
    // The adder clears synchronously, so hold its reset through INIT.
    assign adder_rst  = ((state == S_INIT) || (state == S_FLUSH))
                        ? 4'hF : 4'h0;

    assign out_sum  = adder_sum;
    assign out_cout = adder_cout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_INIT;
            v           <= '0;
            op_count    <= '0;
            stall_count <= '0;
        end else begin
            unique case (state)
                S_INIT: begin
                    v     <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    v <= v_nxt;
                    if (flush) begin
                        state <= S_FLUSH;
                    end else if (drain) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    v <= v_nxt;
                    if (flush) begin
                        state <= S_FLUSH;
                    end else if (!drain) begin
                        state <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    v     <= '0;
                    state <= drain ? S_DRAIN : S_RUN;
                end
            endcase
            if (handoff && (op_count != '1)) begin
                op_count <= op_count + CNT_W'(1);
            end
            if (stalled && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_adder_ctrl.sv
// tb_pipeline_adder_ctrl: randomized checks of the adder sequencer
// against a queue-based reference and a byte-serial adder model.
module tb_pipeline_adder_ctrl;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic             out_cout;
    logic             flush;
    logic             drain;
    logic             drain_done;
    logic [31:0]      adder_a;
    logic [31:0]      adder_b;
    logic             adder_cin;
    logic [3:0]       adder_stop;
    logic [3:0]       adder_rst;
    logic [31:0]      adder_sum;
    logic             adder_cout;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] stall_count;

    pipeline_adder_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .flush(flush), .drain(drain), .drain_done(drain_done),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_stop(adder_stop), .adder_rst(adder_rst),
        .adder_sum(adder_sum), .adder_cout(adder_cout),
        .op_count(op_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Stallable 4-stage adder, one byte per stage, sync active-high clear.
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [31:0] ps [4];
    logic        pc [4];

    always @(posedge clk) begin
        if (adder_rst[0]) begin
            pa[0] <= '0; pb[0] <= '0; ps[0] <= '0; pc[0] <= 1'b0;
        end else if (!adder_stop[0]) begin
            pa[0] <= adder_a;
            pb[0] <= adder_b;
            ps[0][31:8] <= '0;
            {pc[0], ps[0][7:0]} <= 9'(adder_a[7:0]) + 9'(adder_b[7:0])
                                   + 9'(adder_cin);
        end
        for (int i = 1; i < 4; i++) begin
            if (adder_rst[i]) begin
                pa[i] <= '0; pb[i] <= '0; ps[i] <= '0; pc[i] <= 1'b0;
            end else if (!adder_stop[i]) begin
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
                ps[i] <= ps[i-1];
                {pc[i], ps[i][8*i +: 8]} <= 9'(pa[i-1][8*i +: 8])
                    + 9'(pb[i-1][8*i +: 8]) + 9'(pc[i-1]);
            end
        end
    end

    assign adder_sum  = ps[3];
    assign adder_cout = pc[3];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ops_model = 0;
    int          stall_model = 0;
    logic [32:0] exp_q [$];

    logic        s_in_ready, s_out_valid, s_drain_done;
    logic [3:0]  s_stop, s_rst;
    logic [32:0] s_out;
    int          s_inflight;
    logic        acc, hs;
    logic [32:0] got, expv;

    // Called at posedge+1 with inputs set: snapshots outputs mid-cycle,
    // updates the reference queue, then advances one clock.
    task automatic cyc();
        #2;
        s_in_ready   = in_ready;
        s_out_valid  = out_valid;
        s_drain_done = drain_done;
        s_stop       = adder_stop;
        s_rst        = adder_rst;
        s_out        = {out_cout, out_sum};
        s_inflight   = exp_q.size();
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        got = {out_cout, out_sum};
        expv = 'x;
        if (hs) begin
            ops_model++;
            if (exp_q.size() > 0) expv = exp_q.pop_front();
        end
        if (out_valid && !out_ready) stall_model++;
        if (acc) exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + 33'(in_cin));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        in_a   = $urandom;
        in_b   = $urandom;
        in_cin = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 0; in_a = 0; in_b = 0; in_cin = 0;
        out_ready = 1; flush = 0; drain = 0;
        repeat (2) @(posedge clk);
        #3;
        n_tests += 7;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        if (drain_done !== 1'b0) begin
            n_fail++; $display("FAIL rst_drain_done got %b want 0", drain_done);
        end
        if (adder_stop !== 4'h0) begin
            n_fail++; $display("FAIL rst_stop got %h want 0", adder_stop);
        end
        if (adder_rst !== 4'hF) begin
            n_fail++; $display("FAIL rst_adder_rst got %h want f", adder_rst);
        end
        if (op_count !== '0) begin
            n_fail++; $display("FAIL rst_op_count got %0d want 0", op_count);
        end
        if (stall_count !== '0) begin
            n_fail++; $display("FAIL rst_stall got %0d want 0", stall_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc();
        n_tests += 2;
        if (s_rst !== 4'hF) begin
            n_fail++; $display("FAIL init_rst got %h want f", s_rst);
        end
        if (s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL init_ready got %b want 0", s_in_ready);
        end
        cyc();
        n_tests += 2;
        if (s_rst !== 4'h0) begin
            n_fail++; $display("FAIL run_rst got %h want 0", s_rst);
        end
        if (s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL run_ready got %b want 1", s_in_ready);
        end
        in_a = 32'h0000_00FF; in_b = 32'h1; in_cin = 0; in_valid = 1;
        cyc();
        n_tests++;
        if (acc !== 1'b1) begin
            n_fail++; $display("FAIL first_accept got %b want 1", acc);
        end
        in_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_tests++;
            if (s_out_valid !== (k == 4)) begin
                n_fail++;
                $display("FAIL latency k=%0d got %b want %b",
                         k, s_out_valid, (k == 4));
            end
            if (hs) begin
                n_tests++;
                if (got !== 33'h0_0000_0100) begin
                    n_fail++;
                    $display("FAIL first_sum got %h want 000000100", got);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [8];
        logic [31:0] bb [8];
        logic        bc [8];
        int idx = 0, nh = 0, last = 0;
        for (int i = 0; i < 8; i++) begin
            ba[i] = $urandom; bb[i] = $urandom;
            bc[i] = 1'($urandom_range(0, 1));
        end
        ba[3] = 32'hFFFF_FFFF; bb[3] = 32'h0; bc[3] = 1'b1;
        out_ready = 1;
        for (int c = 0; c < 20 && nh < 8; c++) begin
            in_valid = (idx < 8);
            if (idx < 8) begin
                in_a = ba[idx]; in_b = bb[idx]; in_cin = bc[idx];
            end
            cyc();
            if (idx < 8) begin
                n_tests++;
                if (s_in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_ready c=%0d got 0 want 1", c);
                end
            end
            if (acc) idx++;
            if (hs) begin
                n_tests++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL b2b_data got %h want %h", got, expv);
                end
                if (nh == 3) begin
                    n_tests++;
                    if (got !== 33'h1_0000_0000) begin
                        n_fail++;
                        $display("FAIL b2b_wrap got %h want 100000000", got);
                    end
                end
                if (nh > 0) begin
                    n_tests++;
                    if (c - last != 1) begin
                        n_fail++;
                        $display("FAIL b2b_rate gap got %0d want 1", c - last);
                    end
                end
                last = c;
                nh++;
            end
        end
        in_valid = 0;
        n_tests += 2;
        if (nh != 8) begin
            n_fail++; $display("FAIL b2b_count got %0d want 8", nh);
        end
        if (op_count !== CNT_W'(ops_model)) begin
            n_fail++;
            $display("FAIL b2b_op_count got %0d want %0d", op_count, ops_model);
        end
    endtask

    task automatic test_stall();
        int nacc = 0, nh = 0;
        out_ready = 0;
        for (int c = 0; c < 10 && nacc < 4; c++) begin
            in_valid = 1; rand_beat();
            cyc();
            if (acc) nacc++;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1; rand_beat();
            cyc();
            n_tests += 4;
            if (s_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready got 1 want 0");
            end
            if (s_stop !== 4'hF) begin
                n_fail++; $display("FAIL stall_stop got %h want f", s_stop);
            end
            if (s_out_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_valid got 0 want 1");
            end
            if (exp_q.size() == 0 || s_out !== exp_q[0]) begin
                n_fail++; $display("FAIL stall_hold_sum got %h", s_out);
            end
        end
        n_tests++;
        if (stall_count !== CNT_W'(5)) begin
            n_fail++;
            $display("FAIL stall_count got %0d want 5", stall_count);
        end
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (hs) begin
                nh++;
                n_tests++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL stall_data got %h want %h", got, expv);
                end
            end
        end
        n_tests++;
        if (nh != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_drain got %0d results want 4", nh);
        end
    endtask

    task automatic test_bubble();
        logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int nacc = 0, nh = 0;
        out_ready = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = pat[c]; rand_beat();
            cyc();
            if (acc) nacc++;
            n_tests++;
            if (s_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL bub_ready c=%0d got 0 want 1", c);
            end
        end
        n_tests += 2;
        if (nacc != 2) begin
            n_fail++; $display("FAIL bub_accepts got %0d want 2", nacc);
        end
        if (s_stop !== 4'b1100) begin
            n_fail++; $display("FAIL bub_compact got %b want 1100", s_stop);
        end
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; rand_beat();
            cyc();
            n_tests++;
            if (s_in_ready !== (c < 2)) begin
                n_fail++;
                $display("FAIL bub_fill c=%0d got %b want %b",
                         c, s_in_ready, (c < 2));
            end
        end
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (hs) begin
                nh++;
                n_tests++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL bub_data got %h want %h", got, expv);
                end
            end
        end
        n_tests++;
        if (nh != 4) begin
            n_fail++; $display("FAIL bub_count got %0d want 4", nh);
        end
    endtask

    task automatic test_flush();
        int nh = 0;
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; rand_beat();
            cyc();
        end
        flush = 1; in_valid = 1; rand_beat();
        cyc();
        n_tests += 2;
        if (acc !== 1'b0) begin
            n_fail++; $display("FAIL flush_accept got 1 want 0");
        end
        if (s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_req_valid got 1 want 0");
        end
        exp_q.delete();
        flush = 0;
        cyc();
        n_tests += 3;
        if (s_rst !== 4'hF) begin
            n_fail++; $display("FAIL flush_rst got %h want f", s_rst);
        end
        if (s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready got 1 want 0");
        end
        if (s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid got 1 want 0");
        end
        rand_beat();
        cyc();
        n_tests += 2;
        if (s_rst !== 4'h0) begin
            n_fail++; $display("FAIL flush_rst_off got %h want 0", s_rst);
        end
        if (acc !== 1'b1) begin
            n_fail++; $display("FAIL flush_next_accept got 0 want 1");
        end
        in_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_tests++;
            if (s_out_valid !== (k == 4)) begin
                n_fail++;
                $display("FAIL flush_after k=%0d got %b want %b",
                         k, s_out_valid, (k == 4));
            end
            if (hs) begin
                nh++;
                n_tests++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL flush_data got %h want %h", got, expv);
                end
            end
        end
        n_tests++;
        if (nh != 1) begin
            n_fail++; $display("FAIL flush_results got %0d want 1", nh);
        end
    endtask

    task automatic test_drain();
        int  nh = 0;
        logic done = 0;
        out_ready = 1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1; rand_beat();
            cyc();
        end
        drain = 1;
        for (int c = 0; c < 10 && !done; c++) begin
            in_valid = 1; rand_beat();
            cyc();
            n_tests += 2;
            if (s_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL drain_ready c=%0d got 1 want 0", c);
            end
            if (s_drain_done !== (s_inflight == 0)) begin
                n_fail++;
                $display("FAIL drain_done c=%0d got %b want %b",
                         c, s_drain_done, (s_inflight == 0));
            end
            if (hs) begin
                nh++;
                n_tests++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL drain_data got %h want %h", got, expv);
                end
            end
            done = s_drain_done;
        end
        n_tests++;
        if (!done || nh != 2) begin
            n_fail++;
            $display("FAIL drain_end done=%b results=%0d want 1/2", done, nh);
        end
        drain = 0; in_valid = 0;
        cyc();
        cyc();
        n_tests++;
        if (s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL drain_resume got 0 want 1");
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            rand_beat();
            cyc();
            n_tests++;
            if (s_in_ready !== !(s_inflight == 4 && !out_ready)) begin
                n_fail++;
                $display("FAIL rnd_ready c=%0d got %b inflight %0d",
                         c, s_in_ready, s_inflight);
            end
            if (hs) begin
                n_tests++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL rnd_data c=%0d got %h want %h",
                             c, got, expv);
                end
            end
        end
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (hs) begin
                n_tests++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL rnd_tail got %h want %h", got, expv);
                end
            end
        end
        n_tests += 3;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rnd_lost got %0d left want 0", exp_q.size());
        end
        if (op_count !== CNT_W'(ops_model)) begin
            n_fail++;
            $display("FAIL rnd_op_count got %0d want %0d", op_count, ops_model);
        end
        if (stall_count !== CNT_W'(stall_model)) begin
            n_fail++;
            $display("FAIL rnd_stall_count got %0d want %0d",
                     stall_count, stall_model);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_flush();
        test_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_adder_ctrl.md
Name: pipeline_adder_ctrl

Overview:
- Sequencing controller for the 4-stage, 8-bit-per-stage stallable pipelined adder (stage reg i driven by stop[i]/rst[i], both active-high, synchronous in the adder).
- Wraps the adder in a valid/ready stream interface. Tracks per-stage valid bits and generates per-stage stall (stop) and clear (rst) vectors.
- Provides init, flush and drain sequencing plus throughput/stall counters. Sits between an operand producer and a result consumer; the adder instance lives beside it.

Parameters:
CNT_W, 16, width of the completed-operation and stall-cycle counters (saturating).

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  controller accepts beat this cycle
in_a  in  32  operand A
in_b  in  32  operand B
in_cin  in  1  carry-in
out_valid  out  1  result at adder output is valid (= v[3])
out_ready  in  1  consumer accepts result
out_sum  out  32  result (pass-through of adder sum)
out_cout  out  1  carry-out (pass-through of adder c_out)
flush  in  1  synchronous single-cycle request: discard all in-flight ops
drain  in  1  level: stop accepting, let pipeline empty
drain_done  out  1  high while in DRAIN and all v[3:0]=0
adder_a  out  32  to adder cin_a (= in_a, combinational)
adder_b  out  32  to adder cin_b (= in_b, combinational)
adder_cin  out  1  to adder c_in (= in_cin)
adder_stop  out  4  to adder stop[3:0]
adder_rst  out  4  to adder rst[3:0]
adder_sum  in  32  from adder sum
adder_cout  in  1  from adder c_out
op_count  out  CNT_W  results handed off (out_valid & out_ready), saturating
stall_count  out  CNT_W  cycles with out_valid & !out_ready, saturating

Behaviour:
- Reset (rst=0, async): state=INIT; v[3:0]=0; counters=0. Outputs during reset: in_ready=0, out_valid=0, drain_done=0, adder_stop=0, adder_rst=4'hF.
- States: INIT, RUN, DRAIN, FLUSH.
  - INIT: adder_rst=4'hF for exactly one cycle after reset release, in_ready=0, then go to RUN. Required because the adder reset is synchronous.
  - RUN: normal operation. flush -> FLUSH. drain=1 -> DRAIN.
  - DRAIN: in_ready=0; the pipeline continues to advance and hand off.
    - drain_done is combinational: v==0.
    - drain=0 -> RUN. flush -> FLUSH.
  - FLUSH: one cycle. adder_rst=4'hF, v<=0, in_ready=0, out_valid forced 0, no counter update. Next state: DRAIN if drain=1, else RUN.
  - flush has priority over drain and over any handshake in the same cycle.
- Hold logic (combinational):
  - hold[3] = v[3] & !out_ready.
  - hold[i] = v[i] & hold[i+1] for i=2..0.
  - adder_stop = hold (bubbles never stall; a bubble collapses under a downstream stall).
- accept = in_valid & in_ready. in_ready = (state==RUN) & !hold[0].
- Valid update (RUN/DRAIN), per stage:
  - if hold[i], v[i] holds;
  - else v[0] <= accept and v[i] <= v[i-1].
- Latency: beat accepted at edge T gives out_valid high after edge T+3, with no back-pressure. Throughput is 1 result per cycle.
- Back-pressure is lossless. Results leave in acceptance order. out_sum/out_cout stay stable while out_valid & !out_ready.
- adder_rst = 0 outside INIT/FLUSH. Bubbles are not cleared: data in invalid stages is don't-care.
- Counters saturate at all-ones and are not cleared by flush.
- out_valid = v[3] except in FLUSH.

Test Plan:
- Reset release: adder_rst=4'hF for one cycle, then 0; in_ready rises the cycle after. Send a=32'h0000_00FF, b=1, cin=0 -> out_valid 4 cycles after accept, out_sum=32'h0000_0100, out_cout=0.
- Back-to-back stream of 8 beats with out_ready=1. Include a=32'hFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. One result per cycle, in order; op_count=8.
- Stall: fill 4 beats, hold out_ready=0 for 5 cycles.
  - Expect in_ready=0 once full, adder_stop=4'hF, out_sum stable, stall_count=5.
  - Release -> all 4 results emerge, none lost or duplicated.
- Bubble collapse: beats with gaps (valid pattern 1,0,1,0), then out_ready=0. Both beats compact into stages 3 and 2 and in_ready stays high until v[1:0] fill.
- Flush with 3 ops in flight plus an in_valid beat in the same cycle.
  - Expect adder_rst=4'hF for one cycle, beat not accepted, v=0, no out_valid from the flushed ops.
  - Next accepted op returns a correct sum.
- Drain with 2 in flight: in_ready drops immediately; both results emerge; drain_done asserts the cycle v becomes 0. Dropping drain returns to RUN with in_ready=1.
